// File: rtl/gray_ptr_sync_mc.sv
// Multi-channel synchroniser for Gray-coded FIFO pointers in the destination domain.
// Each channel has a flop chain, a registered binary decode, advance and change reporting,
// and a sticky flag for illegal jumps.
module gray_ptr_sync_mc #(
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned NUM_CH      = 1,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MAX_STEP    = 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_CH*(ADDR_WIDTH+1)-1:0]   ptr_gray_in,
  input  logic [NUM_CH-1:0]                  err_clr,
  output logic [NUM_CH*(ADDR_WIDTH+1)-1:0]   ptr_gray_out,
  output logic [NUM_CH*(ADDR_WIDTH+1)-1:0]   ptr_bin_out,
  output logic [NUM_CH*(ADDR_WIDTH+1)-1:0]   ptr_delta,
  output logic [NUM_CH-1:0]                  ptr_changed,
  output logic [NUM_CH-1:0]                  err_sticky
);

  localparam int unsigned PW = ADDR_WIDTH + 1;

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : gen_bad_stages
    $error("gray_ptr_sync_mc: SYNC_STAGES must be in 2..4");
  end
  if (NUM_CH < 1 || NUM_CH > 16) begin : gen_bad_ch
    $error("gray_ptr_sync_mc: NUM_CH must be in 1..16");
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : gen_ch
    logic [PW-1:0] sync_q [SYNC_STAGES];
    logic [PW-1:0] bin_d;
    logic [PW-1:0] bin_q;
    logic [PW-1:0] delta_d;
    logic [PW-1:0] delta_q;
    logic          changed_q;
    logic          err_q;
    logic          step_bad;

    // Pure flop chain: no logic between stages.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      end else begin
        sync_q[0] <= ptr_gray_in[c*PW +: PW];
        for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      end
    end

    always_comb begin
      bin_d = '0;
      for (int i = 0; i < PW; i++) begin
        bin_d[i] = ^(sync_q[SYNC_STAGES-1] >> i);
      end
      delta_d  = bin_d - bin_q;
      // Backward motion wraps to a large modulo delta and is caught here as well.
      step_bad = 32'(delta_d) > MAX_STEP;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        bin_q     <= '0;
        delta_q   <= '0;
        changed_q <= 1'b0;
        err_q     <= 1'b0;
      end else begin
        bin_q     <= bin_d;
        delta_q   <= delta_d;
        changed_q <= (bin_d != bin_q);
        if (step_bad) begin
          err_q <= 1'b1;
        end else if (err_clr[c]) begin
          err_q <= 1'b0;
        end
      end
    end

    assign ptr_gray_out[c*PW +: PW] = sync_q[SYNC_STAGES-1];
    assign ptr_bin_out[c*PW +: PW]  = bin_q;
    assign ptr_delta[c*PW +: PW]    = delta_q;
    assign ptr_changed[c]           = changed_q;
    assign err_sticky[c]            = err_q;
  end

endmodule

// File: doc/gray_ptr_sync_mc.md
# gray_ptr_sync_mc

Multi-channel, parameterised synchroniser for Gray-coded FIFO pointers, located in the destination clock domain of asynchronous FIFOs and multi-queue bridges. Each channel passes its pointer through a configurable-depth flop chain. The block then decodes the synchronised pointer to binary and reports per-cycle advance (delta). It flags illegal pointer jumps with a sticky error bit. This replaces per-FIFO fixed 2-flop pointer synchronisers with one block that is checked by the bench.

## Interface
- ADDR_WIDTH, 4: FIFO address width; pointer width PW = ADDR_WIDTH+1 (MSB is wrap bit)
- NUM_CH, 1: number of independent pointer channels (1..16)
- SYNC_STAGES, 2: synchroniser flop depth (legal 2..4; elaboration error otherwise)
- MAX_STEP, 1: largest legal per-cycle pointer advance; larger advance sets error

- clk  input  1  destination-domain clock
- rst_n  input  1  reset, asynchronous, active-low
- ptr_gray_in  input  NUM_CH*PW  Gray pointers from source-domain registers; channel c at bits [c*PW +: PW]
- err_clr  input  NUM_CH  per-channel synchronous clear of err_sticky
- ptr_gray_out  output  NUM_CH*PW  synchronised Gray pointer (last sync stage)
- ptr_bin_out  output  NUM_CH*PW  registered binary decode of ptr_gray_out
- ptr_delta  output  NUM_CH*PW  registered advance since previous cycle, modulo 2^PW
- ptr_changed  output  NUM_CH  one-cycle pulse, high when ptr_delta != 0
- err_sticky  output  NUM_CH  sticky flag: advance exceeded MAX_STEP

## Operation
- Per channel: sync chain s[0..SYNC_STAGES-1], s[0] <= ptr_gray_in, s[k] <= s[k-1]; ptr_gray_out = s[SYNC_STAGES-1]. No logic between chain flops.
- Decode: bin_next = Gray-to-binary of ptr_gray_out (b[PW-1]=g[PW-1], b[i]=b[i+1]^g[i]); ptr_bin_out <= bin_next.
- Delta: ptr_delta <= (bin_next - ptr_bin_out) mod 2^PW (PW-bit unsigned subtraction, wrap ignored); ptr_changed <= (bin_next != ptr_bin_out).
- Error: if (bin_next - ptr_bin_out) mod 2^PW > MAX_STEP, err_sticky[c] <= 1. Backward movement appears as a large modulo delta and therefore also errors.
- err_clr[c] clears err_sticky[c] next cycle; if a set condition occurs in the same cycle, set wins (flag stays 1).
- Channels are fully independent; no shared state, no cross-channel arbitration.
- Wrap-around: 2^PW-1 -> 0 is delta 1, legal.

## Timing
- Reset (async assert, all flops): every chain stage, ptr_gray_out, ptr_bin_out, ptr_delta = 0; ptr_changed = 0; err_sticky = 0. Outputs go to 0 immediately on rst_n low, including mid-transfer; first post-reset cycle compares against binary 0.
- Latency, stable input change at edge N sampled: ptr_gray_out updates at edge N+SYNC_STAGES-1 (i.e. SYNC_STAGES flops); ptr_bin_out, ptr_delta, ptr_changed, err_sticky update one edge later (SYNC_STAGES+1 flops total).
- ptr_changed is high for exactly one cycle per distinct new value; consecutive different values give back-to-back pulses.
- Input Gray value must change at most one bit per source clock; multi-bit skew in the chain is the source's responsibility and is not corrected here.
- Throughput: one update per clk per channel; no stalls, no handshake.

## Test plan
- Reset/latency, NUM_CH=1, SYNC_STAGES=2: after reset drive gray 00001 -> ptr_gray_out=00001 after 2 edges, ptr_bin_out=00001, ptr_delta=1, ptr_changed pulse 1 cycle after 3 edges; err_sticky=0.
- Wrap: step binary 30->31->0 (gray 10001->10000->00000) one per 4 cycles -> delta 1 each, ptr_bin_out ends 00000, no error.
- Illegal jump: from 0 drive gray 00111 (binary 5) -> ptr_delta=5, err_sticky=1 and held; err_clr pulse -> 0 next cycle; err_clr coincident with another jump -> stays 1.
- SYNC_STAGES=4, MAX_STEP=3: advance by 3 (gray 00010) -> no error, output latency 5 edges; advance by 4 -> error.
- NUM_CH=4: channel 2 only incremented, others static -> only ptr_changed[2] pulses, other channels' outputs unchanged.
- Reset mid-operation: rst_n low while chain holds nonzero values -> all outputs 0 immediately; after release with input gray 00011, ptr_bin_out=00010 and delta=2 (error with MAX_STEP=1).
